// File: rtl/systolic_pkg.sv
// rtl/systolic_pkg.sv - shared sequencer state type and array constants for the systolic sequencer
package systolic_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        FEED,
        FLUSH,
        DRAIN,
        DONE
    } seq_state_t;

    localparam int SYS_N     = 4;
    localparam int SYS_K_MAX = 256;
    localparam int PE_SUM_W  = 32;

endpackage

// File: rtl/systolic_skew_gen.sv
// rtl/systolic_skew_gen.sv - skewed operand enables and indices for one edge of the PE grid
module systolic_skew_gen #(
    parameter int N   = 4,
    parameter int K_W = 9,
    parameter int T_W = 12
) (
    input  logic               i_active,
    input  logic [T_W-1:0]     i_t,
    input  logic [K_W-1:0]     i_k_len,
    output logic [N-1:0]       o_en,
    output logic [N*K_W-1:0]   o_k_idx
);

    logic [T_W-1:0] w_k_ext;

    assign w_k_ext = {{(T_W - K_W){1'b0}}, i_k_len};

    // Lane g lags the wavefront by g cycles, so it carries element t-g.
    for (genvar g = 0; g < N; g++) begin : g_lane
        logic [T_W-1:0] w_off;

        assign w_off             = i_t - T_W'(g);
        assign o_en[g]           = i_active && (i_t >= T_W'(g)) && (w_off < w_k_ext);
        assign o_k_idx[g*K_W +: K_W] = o_en[g] ? w_off[K_W-1:0] : '0;
    end

endmodule

// File: rtl/systolic_seq_ctrl.sv
// rtl/systolic_seq_ctrl.sv - systolic array job sequencer: clear, skewed feed, flush, row drain
// Optional SYSTOLIC_PERF_CNT_EN adds saturating busy/stall cycle counters.
module systolic_seq_ctrl
    import systolic_pkg::*;
#(
    parameter int  N     = SYS_N,
    parameter int  K_MAX = SYS_K_MAX,
    localparam int K_W   = $clog2(K_MAX + 1),
    localparam int R_W   = $clog2(N),
    localparam int T_W   = K_W + $clog2(2 * N)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [K_W-1:0]     k_len,
    output logic               ready,
    output logic               acc_clear,
    output logic [N-1:0]       row_en,
    output logic [N-1:0]       col_en,
    output logic [N*K_W-1:0]   row_k_idx,
    output logic [N*K_W-1:0]   col_k_idx,
    output logic [R_W-1:0]     drain_row,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               done,
    output logic               err
`ifdef SYSTOLIC_PERF_CNT_EN
    ,
    output logic [31:0]        perf_busy_cyc,
    output logic [31:0]        perf_stall_cyc
`endif
);

    seq_state_t     r_state, w_next_state;
    logic [T_W-1:0] r_t, w_next_t;
    logic [K_W-1:0] r_k, w_next_k;
    logic [R_W-1:0] r_row, w_next_row;
    logic           r_err, w_next_err;

    logic [T_W-1:0] w_k_ext;
    logic           w_k_ok;
    logic           w_feed_last;
    logic           w_flush_last;
    logic           w_feeding;

    assign w_k_ext      = {{(T_W - K_W){1'b0}}, r_k};
    assign w_k_ok       = (k_len != '0) && (k_len <= K_W'(K_MAX));
    assign w_feed_last  = (r_t == w_k_ext + T_W'(N - 2));
    // One extra cycle past the last MAC of PE(N-1,N-1) lets its sum register settle.
    assign w_flush_last = (r_t == w_k_ext + T_W'(2 * N - 2));
    assign w_feeding    = (r_state == FEED);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_t     <= '0;
            r_k     <= '0;
            r_row   <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_t     <= w_next_t;
            r_k     <= w_next_k;
            r_row   <= w_next_row;
            r_err   <= w_next_err;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_next_t     = r_t;
        w_next_k     = r_k;
        w_next_row   = r_row;
        w_next_err   = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    if (w_k_ok) begin
                        w_next_k     = k_len;
                        w_next_state = CLEAR;
                    end else begin
                        w_next_err = 1'b1;
                    end
                end
            end
            CLEAR: begin
                w_next_t     = '0;
                w_next_state = FEED;
            end
            FEED: begin
                w_next_t = r_t + T_W'(1);
                if (w_feed_last) begin
                    w_next_state = FLUSH;
                end
            end
            FLUSH: begin
                if (w_flush_last) begin
                    w_next_row   = '0;
                    w_next_state = DRAIN;
                end else begin
                    w_next_t = r_t + T_W'(1);
                end
            end
            DRAIN: begin
                if (out_ready) begin
                    if (r_row == R_W'(N - 1)) begin
                        w_next_state = DONE;
                    end else begin
                        w_next_row = r_row + R_W'(1);
                    end
                end
            end
            DONE: begin
                w_next_row   = '0;
                w_next_state = IDLE;
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    assign ready     = (r_state == IDLE);
    assign acc_clear = (r_state == CLEAR);
    assign out_valid = (r_state == DRAIN);
    assign done      = (r_state == DONE);
    assign drain_row = r_row;
    assign err       = r_err;

    systolic_skew_gen #(
        .N   (N),
        .K_W (K_W),
        .T_W (T_W)
    ) u_row_skew (
        .i_active (w_feeding),
        .i_t      (r_t),
        .i_k_len  (r_k),
        .o_en     (row_en),
        .o_k_idx  (row_k_idx)
    );

    systolic_skew_gen #(
        .N   (N),
        .K_W (K_W),
        .T_W (T_W)
    ) u_col_skew (
        .i_active (w_feeding),
        .i_t      (r_t),
        .i_k_len  (r_k),
        .o_en     (col_en),
        .o_k_idx  (col_k_idx)
    );

`ifdef SYSTOLIC_PERF_CNT_EN
    logic [31:0] r_busy_cyc;
    logic [31:0] r_stall_cyc;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy_cyc  <= '0;
            r_stall_cyc <= '0;
        end else begin
            if ((r_state != IDLE) && (r_busy_cyc != '1)) begin
                r_busy_cyc <= r_busy_cyc + 32'd1;
            end
            if ((r_state == DRAIN) && !out_ready && (r_stall_cyc != '1)) begin
                r_stall_cyc <= r_stall_cyc + 32'd1;
            end
        end
    end

    assign perf_busy_cyc  = r_busy_cyc;
    assign perf_stall_cyc = r_stall_cyc;
`endif

endmodule

// File: tb/tb_systolic_seq_ctrl.sv
// tb/tb_systolic_seq_ctrl.sv - self-checking bench for systolic_seq_ctrl with job model and PE grid
module tb_systolic_seq_ctrl;

    localparam int N     = 4;
    localparam int K_MAX = 256;
    localparam int K_W   = 9;
    localparam int R_W   = 2;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               start = 1'b0;
    logic [K_W-1:0]     k_len = '0;
    logic               out_ready = 1'b0;
    logic               ready;
    logic               acc_clear;
    logic [N-1:0]       row_en;
    logic [N-1:0]       col_en;
    logic [N*K_W-1:0]   row_k_idx;
    logic [N*K_W-1:0]   col_k_idx;
    logic [R_W-1:0]     drain_row;
    logic               out_valid;
    logic               done;
    logic               err;
`ifdef SYSTOLIC_PERF_CNT_EN
    logic [31:0]        perf_busy_cyc;
    logic [31:0]        perf_stall_cyc;
`endif

    systolic_seq_ctrl #(
        .N     (N),
        .K_MAX (K_MAX)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .k_len     (k_len),
        .ready     (ready),
        .acc_clear (acc_clear),
        .row_en    (row_en),
        .col_en    (col_en),
        .row_k_idx (row_k_idx),
        .col_k_idx (col_k_idx),
        .drain_row (drain_row),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .done      (done),
        .err       (err)
`ifdef SYSTOLIC_PERF_CNT_EN
        ,
        .perf_busy_cyc  (perf_busy_cyc),
        .perf_stall_cyc (perf_stall_cyc)
`endif
    );

    always #5 clk = ~clk;

    int  checks = 0;
    int  errors = 0;
    bit  armed  = 1'b0;

    byte A [N][K_MAX];
    byte B [K_MAX][N];
    int  gold [N][N];
    int  acc  [N][N];
    byte pa   [N][N];
    byte pb   [N][N];
    bit  pav  [N][N];
    bit  pbv  [N][N];

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Job model: cycle 1 after acceptance is the clear, cycles 2..k+2N walk t=0..k+2N-2,
    // then rows drain one per handshake, then a single done cycle.
    initial begin : cmp
        bit          m_busy, m_drain, m_done, m_err;
        int          m_c, m_k, m_row, t, ri, ci;
        longint      m_bcyc, m_scyc, s;
        logic [N-1:0] e_en;
        m_busy = 0; m_drain = 0; m_done = 0; m_err = 0;
        m_c = 0; m_k = 0; m_row = 0; m_bcyc = 0; m_scyc = 0;
        forever begin
            @(negedge clk);
            t = m_c - 2;
            for (int i = 0; i < N; i++)
                e_en[i] = m_busy && !m_drain && !m_done && (m_c >= 2) && (t >= i) && (t - i < m_k);
            if (armed) begin
                check("ready", ready, !m_busy);
                check("acc_clear", acc_clear, m_busy && !m_drain && !m_done && (m_c == 1));
                check("row_en", row_en, e_en);
                check("col_en", col_en, e_en);
                for (int i = 0; i < N; i++) begin
                    if (e_en[i]) begin
                        check("row_k_idx", row_k_idx[i*K_W +: K_W], t - i);
                        check("col_k_idx", col_k_idx[i*K_W +: K_W], t - i);
                    end
                end
                check("out_valid", out_valid, m_drain);
                if (m_drain) check("drain_row", drain_row, m_row);
                check("done", done, m_done);
                check("err", err, m_err);
`ifdef SYSTOLIC_PERF_CNT_EN
                check("perf_busy", perf_busy_cyc, m_bcyc);
                check("perf_stall", perf_stall_cyc, m_scyc);
`endif
                if (m_drain && out_ready)
                    for (int j = 0; j < N; j++) check("result", acc[m_row][j], gold[m_row][j]);
            end
            // PE grid fed by the DUT edges: operands move east/south one PE per cycle
            if (acc_clear) begin
                for (int i = 0; i < N; i++)
                    for (int j = 0; j < N; j++) begin
                        acc[i][j] = 0; pav[i][j] = 0; pbv[i][j] = 0;
                    end
            end else begin
                for (int i = N - 1; i >= 0; i--)
                    for (int j = N - 1; j >= 0; j--) begin
                        if (j == 0) begin
                            ri = int'(row_k_idx[i*K_W +: K_W]);
                            pav[i][0] = row_en[i] && (ri < K_MAX);
                            pa[i][0]  = pav[i][0] ? A[i][ri] : 8'sd0;
                        end else begin
                            pav[i][j] = pav[i][j-1];
                            pa[i][j]  = pa[i][j-1];
                        end
                        if (i == 0) begin
                            ci = int'(col_k_idx[j*K_W +: K_W]);
                            pbv[0][j] = col_en[j] && (ci < K_MAX);
                            pb[0][j]  = pbv[0][j] ? B[ci][j] : 8'sd0;
                        end else begin
                            pbv[i][j] = pbv[i-1][j];
                            pb[i][j]  = pb[i-1][j];
                        end
                        if (pav[i][j] && pbv[i][j]) acc[i][j] += int'(pa[i][j]) * int'(pb[i][j]);
                    end
            end
            if (rst) begin
                m_busy = 0; m_drain = 0; m_done = 0; m_err = 0;
                m_c = 0; m_bcyc = 0; m_scyc = 0;
            end else begin
                if (m_busy && m_bcyc < 64'hFFFF_FFFF) m_bcyc++;
                if (m_drain && !out_ready && m_scyc < 64'hFFFF_FFFF) m_scyc++;
                m_err = 0;
                if (!m_busy) begin
                    if (start) begin
                        if (k_len >= 1 && k_len <= K_MAX) begin
                            m_busy = 1; m_c = 1; m_k = int'(k_len);
                            for (int i = 0; i < N; i++)
                                for (int j = 0; j < N; j++) begin
                                    s = 0;
                                    for (int kk = 0; kk < m_k; kk++) s += int'(A[i][kk]) * int'(B[kk][j]);
                                    gold[i][j] = int'(s);
                                end
                        end else begin
                            m_err = 1;
                        end
                    end
                end else if (m_done) begin
                    m_busy = 0; m_done = 0;
                end else if (m_drain) begin
                    if (out_ready) begin
                        if (m_row == N - 1) begin m_drain = 0; m_done = 1; end
                        else m_row++;
                    end
                end else if (m_c < m_k + 2 * N) begin
                    m_c++;
                end else begin
                    m_drain = 1; m_row = 0;
                end
            end
        end
    end

    function automatic bit ready_pat(input int d);
        bit [3:0] pat;
        pat = 4'b1001;
        return (d < 0) ? 1'b1 : pat[3 - (d % 4)];
    endfunction

    task automatic run_job(input int k, input int mode, input bit poke,
                           output int n_done, output int n_valid);
        int  d0;
        bit  fin;
        n_done = 0; n_valid = 0; fin = 0;
        d0 = k + 2 * N + 1;
        @(posedge clk); #1;
        start = 1'b1; k_len = K_W'(k); out_ready = 1'b1;
        for (int cyc = 1; cyc <= k + 40 && !fin; cyc++) begin
            @(posedge clk); #1;
            start = poke && (cyc == d0 + 1);
            if (poke) k_len = K_W'(3);
            out_ready = (mode == 0) ? 1'b1 : ready_pat(cyc - d0);
            if (out_valid) n_valid++;
            if (done) begin n_done++; fin = 1; end
        end
        if (!fin) begin
            checks++; errors++;
            $display("FAIL job_timeout: got no done expected done for k=%0d", k);
        end
        out_ready = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
            if (done) n_done++;
        end
    endtask

    task automatic job_k1();
        int clear_cyc, first_v, n_done;
        bit fin;
        logic [N-1:0] en_h [8];
        clear_cyc = -1; first_v = -1; n_done = 0; fin = 0;
        @(posedge clk); #1;
        start = 1'b1; k_len = K_W'(1); out_ready = 1'b1;
        for (int cyc = 1; cyc <= 40 && !fin; cyc++) begin
            @(posedge clk); #1;
            start = 1'b0;
            if (acc_clear && clear_cyc < 0) clear_cyc = cyc;
            if (cyc < 8) en_h[cyc] = row_en;
            if (out_valid && first_v < 0) first_v = cyc;
            if (done) begin n_done++; fin = 1; end
        end
        check("k1_clear_cycle", clear_cyc, 1);
        check("k1_row_en_t0", en_h[2], 4'b0001);
        check("k1_row_en_t1", en_h[3], 4'b0010);
        check("k1_row_en_t2", en_h[4], 4'b0100);
        check("k1_row_en_t3", en_h[5], 4'b1000);
        check("k1_row_en_flush", en_h[6], 4'b0000);
        check("k1_latency", first_v - 1, 9);
        check("k1_done_count", n_done, 1);
        repeat (2) @(posedge clk);
    endtask

    task automatic bad_start(input int k);
        int n_err, n_clr, n_busy;
        n_err = 0; n_clr = 0; n_busy = 0;
        @(posedge clk); #1;
        start = 1'b1; k_len = K_W'(k);
        for (int cyc = 1; cyc <= 6; cyc++) begin
            @(posedge clk); #1;
            start = 1'b0;
            if (err) n_err++;
            if (acc_clear) n_clr++;
            if (!ready) n_busy++;
        end
        check("bad_k_err_pulses", n_err, 1);
        check("bad_k_acc_clear", n_clr, 0);
        check("bad_k_not_ready", n_busy, 0);
    endtask

    task automatic rst_mid_feed();
        int n_done;
        n_done = 0;
        @(posedge clk); #1;
        start = 1'b1; k_len = K_W'(8); out_ready = 1'b1;
        for (int cyc = 1; cyc <= 5; cyc++) begin
            @(posedge clk); #1;
            start = 1'b0;
        end
        check("feed_t3_row_en", row_en, 4'b1111);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("rst_ready", ready, 1);
        check("rst_row_en", row_en, 0);
        check("rst_col_en", col_en, 0);
        repeat (20) begin
            @(posedge clk); #1;
            if (done) n_done++;
        end
        check("rst_no_done", n_done, 0);
    endtask

    initial begin : stim
        int nd, nv;
`ifdef SYSTOLIC_PERF_CNT_EN
        longint s0;
`endif
        for (int i = 0; i < N; i++)
            for (int k = 0; k < K_MAX; k++) A[i][k] = byte'(i * 37 + k * 13 + 5);
        for (int k = 0; k < K_MAX; k++)
            for (int j = 0; j < N; j++) B[k][j] = byte'(k * 29 - j * 17 + 3);

        rst = 1'b1;
        @(posedge clk); #1;
        armed = 1'b1;
        @(posedge clk); #1;
        check("reset_ready", ready, 1);
        check("reset_acc_clear", acc_clear, 0);
        check("reset_row_en", row_en, 0);
        check("reset_out_valid", out_valid, 0);
        check("reset_done", done, 0);
        check("reset_err", err, 0);
        rst = 1'b0;

        job_k1();

        run_job(8, 0, 1'b0, nd, nv);
        check("k8_done_count", nd, 1);
        check("k8_valid_cycles", nv, 4);

`ifdef SYSTOLIC_PERF_CNT_EN
        s0 = perf_stall_cyc;
`endif
        run_job(8, 1, 1'b0, nd, nv);
        check("k8_toggle_done_count", nd, 1);
        check("k8_toggle_valid_cycles", nv, 8);
`ifdef SYSTOLIC_PERF_CNT_EN
        check("k8_toggle_stall_cycles", longint'(perf_stall_cyc) - s0, 4);
`endif

        bad_start(0);
        bad_start(K_MAX + 1);

        rst_mid_feed();
        run_job(5, 0, 1'b0, nd, nv);
        check("after_rst_done_count", nd, 1);
        check("after_rst_valid_cycles", nv, 4);

        run_job(8, 0, 1'b1, nd, nv);
        check("poke_done_count", nd, 1);

        run_job(K_MAX, 1, 1'b0, nd, nv);
        check("kmax_done_count", nd, 1);
        check("kmax_valid_cycles", nv, 8);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
